// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through dcache SHCT: signature width,
// training-event record, FSM state encoding and the signature-to-index hash.
package wt_cache_pkg;

    localparam int unsigned SHCT_SIG_WIDTH   = 14;
    localparam int unsigned SHCT_TRAIN_WIDTH = SHCT_SIG_WIDTH + 1;

    typedef struct packed {
        logic [SHCT_SIG_WIDTH-1:0] sig;
        logic                      is_hit;
    } shct_train_t;

    typedef enum logic {
        SHCT_INIT = 1'b0,
        SHCT_RUN  = 1'b1
    } shct_state_e;

    // Folds the upper signature bits onto the low idx_w bits; callers truncate.
    function automatic logic [SHCT_SIG_WIDTH-1:0] shct_idx(
        input logic [SHCT_SIG_WIDTH-1:0] sig,
        input int unsigned               idx_w
    );
        logic [SHCT_SIG_WIDTH-1:0] mask;
        mask = (SHCT_SIG_WIDTH'(1) << idx_w) - SHCT_SIG_WIDTH'(1);
        return (sig & mask) ^ (sig >> idx_w);
    endfunction

endpackage

// File: rtl/wt_dcache_shct_fifo.sv
// Training-event FIFO for the SHCT: up to two pushes (slot 0 first) and one pop
// per cycle, with a free-slot count taken from the start-of-cycle occupancy.
module wt_dcache_shct_fifo
    import wt_cache_pkg::*;
#(
    parameter int unsigned Depth = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              push0_i,
    input  logic [SHCT_TRAIN_WIDTH-1:0]       push0_data_i,
    input  logic                              push1_i,
    input  logic [SHCT_TRAIN_WIDTH-1:0]       push1_data_i,
    input  logic                              pop_i,
    output logic [SHCT_TRAIN_WIDTH-1:0]       data_o,
    output logic                              empty_o,
    output logic [$clog2(Depth):0]            free_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned CntW = PtrW + 1;

    logic [SHCT_TRAIN_WIDTH-1:0] r_mem [Depth];
    logic [PtrW-1:0]             r_wr_ptr;
    logic [PtrW-1:0]             r_rd_ptr;
    logic [CntW-1:0]             r_count;
    logic [PtrW-1:0]             w_wr1_ptr;

    // A lone slot-1 push lands at the write pointer itself.
    assign w_wr1_ptr = r_wr_ptr + PtrW'(push0_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PtrW'(push0_i) + PtrW'(push1_i);
            if (pop_i) begin
                r_rd_ptr <= r_rd_ptr + PtrW'(1);
            end
            r_count <= r_count + CntW'(push0_i) + CntW'(push1_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push0_i) begin
            r_mem[r_wr_ptr] <= push0_data_i;
        end
        if (push1_i) begin
            r_mem[w_wr1_ptr] <= push1_data_i;
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign empty_o = (r_count == '0);
    assign free_o  = CntW'(Depth) - r_count;

endmodule

// File: rtl/wt_dcache_shct.sv
// Signature History Counter Table: predicts refill insertion class from a 14-bit
// load signature. Optional statistics counters under WT_DCACHE_SHCT_STATS_EN.
module wt_dcache_shct
    import wt_cache_pkg::*;
#(
    parameter int unsigned IdxWidth  = 10,
    parameter int unsigned CntWidth  = 3,
    parameter int unsigned FifoDepth = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      lkp_req_i,
    input  logic [SHCT_SIG_WIDTH-1:0] lkp_sig_i,
    output logic                      lkp_gnt_o,
    output logic                      lkp_vld_o,
    output logic [CntWidth-1:0]       lkp_cnt_o,
    output logic                      lkp_dist_o,
    input  logic                      hit_vld_i,
    input  logic [SHCT_SIG_WIDTH-1:0] hit_sig_i,
    input  logic                      evict_vld_i,
    input  logic [SHCT_SIG_WIDTH-1:0] evict_sig_i,
    input  logic                      evict_ever_hit_i,
    output logic                      init_done_o,
    output logic [15:0]               stat_drop_o,
    output logic [31:0]               stat_lkp_o,
    output logic                      dbg_state_o
);

    localparam int unsigned          Entries  = 1 << IdxWidth;
    localparam int unsigned          FreeW    = $clog2(FifoDepth) + 1;
    localparam logic [CntWidth-1:0]  CNT_INIT = {1'b1, {(CntWidth-1){1'b0}}};
    localparam logic [CntWidth-1:0]  CNT_MAX  = '1;

    shct_state_e                 r_state;
    shct_state_e                 w_state_nxt;
    logic                        w_init_wr;
    logic [IdxWidth-1:0]         r_walk;
    logic [CntWidth-1:0]         r_table [Entries];

    logic                        w_run;
    logic [IdxWidth-1:0]         w_lkp_idx;
    logic                        r_lkp_vld;
    logic [CntWidth-1:0]         r_lkp_cnt;
    logic                        r_lkp_dist;

    logic                        w_hit_ev;
    logic                        w_evt_ev;
    logic                        w_push_hit;
    logic                        w_push_evt;
    logic [FreeW-1:0]            w_fifo_free;
    logic                        w_fifo_empty;
    logic [SHCT_TRAIN_WIDTH-1:0] w_fifo_data;
    logic                        w_pop;
    shct_train_t                 w_pop_entry;
    logic [IdxWidth-1:0]         w_pop_idx;
    logic [CntWidth-1:0]         w_pop_cnt;
    logic [CntWidth-1:0]         w_pop_cnt_nxt;

    // ---------------- FSM: INIT walks the table, RUN serves traffic ----------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= SHCT_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_init_wr   = 1'b0;
        case (r_state)
            SHCT_INIT: begin
                w_init_wr = 1'b1;
                if (r_walk == '1) begin
                    w_state_nxt = SHCT_RUN;
                end
            end
            SHCT_RUN: begin
                w_state_nxt = SHCT_RUN;
            end
            default: begin
                w_state_nxt = SHCT_INIT;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_walk <= '0;
        end else if (w_init_wr) begin
            r_walk <= r_walk + IdxWidth'(1);
        end
    end

    assign w_run       = (r_state == SHCT_RUN);
    assign init_done_o = w_run;
    assign dbg_state_o = r_state;

    // Lookup handshake: lkp_gnt_o is the same-cycle accept of lkp_req_i; an
    // accepted request returns exactly one lkp_vld_o pulse on the next cycle.
    assign lkp_gnt_o = lkp_req_i & w_run & ~rst_i;
    assign w_lkp_idx = IdxWidth'(shct_idx(lkp_sig_i, IdxWidth));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lkp_vld  <= 1'b0;
            r_lkp_cnt  <= '0;
            r_lkp_dist <= 1'b0;
        end else begin
            r_lkp_vld <= lkp_gnt_o;
            if (lkp_gnt_o) begin
                r_lkp_cnt  <= r_table[w_lkp_idx];
                r_lkp_dist <= (r_table[w_lkp_idx] == '0);
            end
        end
    end

    assign lkp_vld_o  = r_lkp_vld;
    assign lkp_cnt_o  = r_lkp_cnt;
    assign lkp_dist_o = r_lkp_dist;

    // ---------------- Training: push arbitration, hit wins the last slot ----------------
    assign w_hit_ev   = hit_vld_i;
    assign w_evt_ev   = evict_vld_i & ~evict_ever_hit_i;
    assign w_push_hit = w_hit_ev & (w_fifo_free != '0);
    assign w_push_evt = w_evt_ev & (w_fifo_free > FreeW'(w_push_hit));

    assign w_pop = w_run & ~w_fifo_empty & ~lkp_gnt_o & ~rst_i;

    wt_dcache_shct_fifo #(
        .Depth        (FifoDepth)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push0_i      (w_push_hit),
        .push0_data_i ({hit_sig_i, 1'b1}),
        .push1_i      (w_push_evt),
        .push1_data_i ({evict_sig_i, 1'b0}),
        .pop_i        (w_pop),
        .data_o       (w_fifo_data),
        .empty_o      (w_fifo_empty),
        .free_o       (w_fifo_free)
    );

    assign w_pop_entry = w_fifo_data;
    assign w_pop_idx   = IdxWidth'(shct_idx(w_pop_entry.sig, IdxWidth));
    assign w_pop_cnt   = r_table[w_pop_idx];

    always_comb begin
        w_pop_cnt_nxt = w_pop_cnt;
        if (w_pop_entry.is_hit) begin
            if (w_pop_cnt != CNT_MAX) begin
                w_pop_cnt_nxt = w_pop_cnt + CntWidth'(1);
            end
        end else if (w_pop_cnt != '0) begin
            w_pop_cnt_nxt = w_pop_cnt - CntWidth'(1);
        end
    end

    // INIT and RUN are exclusive, so the walk and the pop never collide.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_init_wr) begin
                r_table[r_walk] <= CNT_INIT;
            end else if (w_pop) begin
                r_table[w_pop_idx] <= w_pop_cnt_nxt;
            end
        end
    end

    // ---------------- Statistics ----------------
`ifdef WT_DCACHE_SHCT_STATS_EN
    logic [15:0] r_stat_drop;
    logic [31:0] r_stat_lkp;
    logic [1:0]  w_drop_n;
    logic [16:0] w_drop_sum;

    assign w_drop_n   = 2'(w_hit_ev & ~w_push_hit) + 2'(w_evt_ev & ~w_push_evt);
    assign w_drop_sum = {1'b0, r_stat_drop} + 17'(w_drop_n);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stat_drop <= '0;
            r_stat_lkp  <= '0;
        end else begin
            r_stat_drop <= w_drop_sum[16] ? '1 : w_drop_sum[15:0];
            if (lkp_gnt_o && (r_stat_lkp != '1)) begin
                r_stat_lkp <= r_stat_lkp + 32'd1;
            end
        end
    end

    assign stat_drop_o = r_stat_drop;
    assign stat_lkp_o  = r_stat_lkp;
`else
    assign stat_drop_o = '0;
    assign stat_lkp_o  = '0;
`endif

endmodule

// File: tb/tb_wt_dcache_shct.sv
// Bench for wt_dcache_shct: directed scenarios plus random traffic, checked every
// cycle against a table/queue model of the SHCT rules.
module tb_wt_dcache_shct;

    localparam int ENTRIES = 1024;
    localparam int DEPTH   = 4;
    localparam int CMAX    = 7;
    localparam int CINIT   = 4;
`ifdef WT_DCACHE_SHCT_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_i;
    logic        lkp_req_i;
    logic [13:0] lkp_sig_i;
    logic        lkp_gnt_o;
    logic        lkp_vld_o;
    logic [2:0]  lkp_cnt_o;
    logic        lkp_dist_o;
    logic        hit_vld_i;
    logic [13:0] hit_sig_i;
    logic        evict_vld_i;
    logic [13:0] evict_sig_i;
    logic        evict_ever_hit_i;
    logic        init_done_o;
    logic [15:0] stat_drop_o;
    logic [31:0] stat_lkp_o;
    logic        dbg_state_o;

    always #5 clk = ~clk;

    wt_dcache_shct dut (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .lkp_req_i        (lkp_req_i),
        .lkp_sig_i        (lkp_sig_i),
        .lkp_gnt_o        (lkp_gnt_o),
        .lkp_vld_o        (lkp_vld_o),
        .lkp_cnt_o        (lkp_cnt_o),
        .lkp_dist_o       (lkp_dist_o),
        .hit_vld_i        (hit_vld_i),
        .hit_sig_i        (hit_sig_i),
        .evict_vld_i      (evict_vld_i),
        .evict_sig_i      (evict_sig_i),
        .evict_ever_hit_i (evict_ever_hit_i),
        .init_done_o      (init_done_o),
        .stat_drop_o      (stat_drop_o),
        .stat_lkp_o       (stat_lkp_o),
        .dbg_state_o      (dbg_state_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          mdl_tab [ENTRIES];
    logic [14:0] exp_q[$];          // {is_hit, sig}
    int          mdl_cycles = 0;    // non-reset cycles since the last reset
    bit          mdl_started = 0;
    bit          exp_vld = 0;
    int          exp_cnt = 0;
    bit          exp_dist = 0;
    int          exp_drop = 0;
    longint      exp_lkp = 0;

    function automatic int mdl_idx(input int sig);
        return (sig % ENTRIES) ^ (sig / ENTRIES);
    endfunction

    task automatic mdl_drop();
        if (exp_drop < 65535) exp_drop++;
    endtask

    task automatic mdl_step();
        int          free;
        int          v;
        int          ix;
        bit          run;
        logic [14:0] e;
        if (rst_i) begin
            mdl_started = 1;
            mdl_cycles  = 0;
            exp_q.delete();
            foreach (mdl_tab[i]) mdl_tab[i] = CINIT;
            exp_vld  = 0;
            exp_cnt  = 0;
            exp_dist = 0;
            exp_drop = 0;
            exp_lkp  = 0;
            return;
        end
        if (!mdl_started) return;
        run     = (mdl_cycles >= ENTRIES);
        free    = DEPTH - exp_q.size();
        exp_vld = 0;
        if (lkp_req_i && run) begin
            v        = mdl_tab[mdl_idx(int'(lkp_sig_i))];
            exp_vld  = 1;
            exp_cnt  = v;
            exp_dist = (v == 0);
            if (exp_lkp < 64'h0000_0000_FFFF_FFFF) exp_lkp++;
        end else if (run && exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ix = mdl_idx(int'(e[13:0]));
            if (e[14]) mdl_tab[ix] = (mdl_tab[ix] >= CMAX) ? CMAX : mdl_tab[ix] + 1;
            else       mdl_tab[ix] = (mdl_tab[ix] <= 0) ? 0 : mdl_tab[ix] - 1;
        end
        if (hit_vld_i) begin
            if (free > 0) begin
                exp_q.push_back({1'b1, hit_sig_i});
                free--;
            end else mdl_drop();
        end
        if (evict_vld_i && !evict_ever_hit_i) begin
            if (free > 0) exp_q.push_back({1'b0, evict_sig_i});
            else mdl_drop();
        end
        if (mdl_cycles < ENTRIES) mdl_cycles++;
    endtask

    initial forever begin
        @(posedge clk);
        mdl_step();
    end

    // Compare process: outputs sampled on the falling edge.
    initial forever begin
        bit run;
        @(negedge clk);
        if (mdl_started) begin
            run = (mdl_cycles >= ENTRIES);
            check("gnt", lkp_gnt_o, lkp_req_i && run && !rst_i);
            check("vld", lkp_vld_o, exp_vld);
            if (exp_vld) begin
                check("cnt", lkp_cnt_o, exp_cnt);
                check("dist", lkp_dist_o, exp_dist);
            end
            check("init_done", init_done_o, run);
            check("dbg_state", dbg_state_o, run);
            check("stat_drop", stat_drop_o, STATS ? exp_drop : 0);
            check("stat_lkp", stat_lkp_o, STATS ? exp_lkp : 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input bit req, input logic [13:0] ls, input bit hv, input logic [13:0] hs,
                         input bit ev, input logic [13:0] es, input bit eh);
        lkp_req_i        = req;
        lkp_sig_i        = ls;
        hit_vld_i        = hv;
        hit_sig_i        = hs;
        evict_vld_i      = ev;
        evict_sig_i      = es;
        evict_ever_hit_i = eh;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 14'h0, 0, 14'h0, 0, 14'h0, 0);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        idle(1);
        rst_i = 1'b0;
    endtask

    task automatic lookup_expect(input string name, input logic [13:0] sig, input int cnt);
        drive(1, sig, 0, 14'h0, 0, 14'h0, 0);
        lkp_req_i = 1'b0;
        check({name, "_vld"}, lkp_vld_o, 1);
        check({name, "_cnt"}, lkp_cnt_o, cnt);
        check({name, "_dist"}, lkp_dist_o, cnt == 0);
        check({name, "_model"}, mdl_tab[mdl_idx(int'(sig))], cnt);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [13:0] s0;
        logic [13:0] s1;
        logic [13:0] s2;
        rst_i = 1'b1;
        lkp_req_i = 1'b1;
        lkp_sig_i = 14'h0;
        hit_vld_i = 1'b0;
        hit_sig_i = 14'h0;
        evict_vld_i = 1'b0;
        evict_sig_i = 14'h0;
        evict_ever_hit_i = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_gnt", lkp_gnt_o, 0);
        check("rst_vld", lkp_vld_o, 0);
        check("rst_cnt", lkp_cnt_o, 0);
        check("rst_dist", lkp_dist_o, 0);
        check("rst_init_done", init_done_o, 0);
        check("rst_stat_drop", stat_drop_o, 0);
        check("rst_stat_lkp", stat_lkp_o, 0);
        lkp_req_i = 1'b0;
        rst_i = 1'b0;

        idle(1023);
        check("init_not_yet", init_done_o, 0);
        idle(1);
        check("init_rise", init_done_o, 1);
        check("hash_0400", mdl_idx(32'h0400), 1);
        check("hash_3fff", mdl_idx(32'h3fff), 32'h3f0);

        lookup_expect("init_0123", 14'h0123, 4);
        repeat (4) drive(0, 14'h0, 0, 14'h0, 1, 14'h0123, 0);
        idle(3);
        lookup_expect("evict4", 14'h0123, 0);
        drive(0, 14'h0, 0, 14'h0, 1, 14'h0123, 0);
        idle(2);
        lookup_expect("evict5_sat", 14'h0123, 0);

        repeat (5) drive(0, 14'h0, 1, 14'h0055, 0, 14'h0, 0);
        idle(3);
        lookup_expect("hit5_sat", 14'h0055, 7);
        drive(0, 14'h0, 0, 14'h0, 1, 14'h0055, 1);
        idle(2);
        lookup_expect("evict_everhit", 14'h0055, 7);

        drive(0, 14'h0, 1, 14'h0400, 0, 14'h0, 0);
        idle(2);
        lookup_expect("alias_0001", 14'h0001, 5);

        check("drop_before", stat_drop_o, 0);
        drive(1, 14'h0100, 1, 14'h0010, 0, 14'h0, 0);
        drive(1, 14'h0100, 1, 14'h0011, 0, 14'h0, 0);
        drive(1, 14'h0100, 1, 14'h0012, 0, 14'h0, 0);
        drive(1, 14'h0100, 1, 14'h0001, 1, 14'h0002, 0);
        check("drop_one", stat_drop_o, STATS ? 1 : 0);
        idle(6);
        lookup_expect("drop_hit_kept", 14'h0001, 6);
        lookup_expect("drop_evict_lost", 14'h0002, 4);
        lookup_expect("queued_hit_0010", 14'h0010, 5);

        // Reset in the middle of INIT.
        do_reset();
        idle(500);
        do_reset();
        check("reinit_fifo_empty", exp_q.size(), 0);
        idle(1023);
        check("reinit_not_yet", init_done_o, 0);
        idle(1);
        check("reinit_rise", init_done_o, 1);
        lookup_expect("reinit_0123", 14'h0123, 4);
        lookup_expect("reinit_0055", 14'h0055, 4);
        lookup_expect("reinit_0001", 14'h0001, 4);

        // Reset in RUN with three queued hits.
        drive(1, 14'h0200, 1, 14'h0300, 0, 14'h0, 0);
        drive(1, 14'h0200, 1, 14'h0301, 0, 14'h0, 0);
        drive(1, 14'h0200, 1, 14'h0302, 0, 14'h0, 0);
        do_reset();
        check("runrst_vld", lkp_vld_o, 0);
        check("runrst_init_done", init_done_o, 0);
        idle(1024);
        lookup_expect("runrst_0300", 14'h0300, 4);
        lookup_expect("runrst_0301", 14'h0301, 4);
        lookup_expect("runrst_0302", 14'h0302, 4);

        // Random traffic over a small signature pool so counters move.
        repeat (3000) begin
            s0 = 14'($urandom_range(0, 7)) | (14'($urandom_range(0, 1)) << 10);
            s1 = 14'($urandom_range(0, 7)) | (14'($urandom_range(0, 1)) << 10);
            s2 = 14'($urandom_range(0, 7)) | (14'($urandom_range(0, 1)) << 10);
            drive($urandom_range(0, 2) == 0, s0,
                  $urandom_range(0, 1) == 1, s1,
                  $urandom_range(0, 1) == 1, s2,
                  $urandom_range(0, 3) == 0);
        end
        idle(8);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
